// File: rtl/vx_tcu_tfr_normalize_pkg.sv
// Shared widths, flag indices, result layout and leading-one helper for the TFR normaliser.
package vx_tcu_tfr_normalize_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int FRAC_W = 23;
   localparam int SUM_W  = 28;
   localparam int TAG_W  = 8;
   localparam int EW     = EXP_W + 2;
   localparam int LZC_W  = $clog2(SUM_W);

   localparam int TFR_FLAG_ZERO = 2;
   localparam int TFR_FLAG_OVF  = 1;
   localparam int TFR_FLAG_UF   = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } tfr_result_t;

   // Highest set bit index; returns 0 for an all-zero vector.
   function automatic logic [LZC_W-1:0] lead_one(input logic [SUM_W-1:0] v);
      logic [LZC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < SUM_W; i++) begin
         if (v[i]) idx = LZC_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/vx_tcu_tfr_normalize_if.sv
// Input/output stream bundle of the TFR normaliser; slave is the block's view.
interface vx_tcu_tfr_normalize_if;
   import vx_tcu_tfr_normalize_pkg::*;

   logic             valid_in;
   logic             ready_in;
   logic [SUM_W-1:0] sum_in;
   logic [EXP_W-1:0] max_exp_in;
   logic [TAG_W-1:0] tag_in;
   logic             valid_out;
   logic             ready_out;
   tfr_result_t      result_out;
   logic [2:0]       flags_out;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output valid_in, sum_in, max_exp_in, tag_in, ready_out,
      input  ready_in, valid_out, result_out, flags_out, tag_out
   );

   modport slave (
      input  valid_in, sum_in, max_exp_in, tag_in, ready_out,
      output ready_in, valid_out, result_out, flags_out, tag_out
   );

endinterface

// File: rtl/vx_tcu_tfr_normalize_round.sv
// Combinational RNE rounding, exponent adjust and packing of a normalised magnitude.
// The leading bit of norm is the hidden one; a clear leading bit means the sum was zero.
module vx_tcu_tfr_normalize_round
   import vx_tcu_tfr_normalize_pkg::*;
(
   input  logic                 sign,
   input  logic [SUM_W-1:0]     norm,
   input  logic signed [EW-1:0] exp,
   output tfr_result_t          result,
   output logic [2:0]           flags
);

   localparam int GRD = SUM_W - 2 - MAN_W;
   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ZERO = '0;

   logic                 zero;
   logic [MAN_W-1:0]     man;
   logic                 guard;
   logic                 sticky;
   logic                 rnd;
   logic [MAN_W:0]       man_rnd;
   logic signed [EW-1:0] e_adj;

   assign zero    = ~norm[SUM_W-1];
   assign man     = norm[SUM_W-2 -: MAN_W];
   assign guard   = norm[GRD];
   assign sticky  = |norm[GRD-1:0];
   assign rnd     = guard & (sticky | man[0]);
   assign man_rnd = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
   // A carry out leaves the low MAN_W bits at zero, so only the exponent moves.
   assign e_adj   = exp + $signed({{(EW-1){1'b0}}, man_rnd[MAN_W]});

   always_comb begin
      result = '0;
      flags  = '0;
      if (zero) begin
         flags[TFR_FLAG_ZERO] = 1'b1;
      end else if (e_adj >= E_MAX) begin
         result.sign         = sign;
         result.exp          = '1;
         flags[TFR_FLAG_OVF] = 1'b1;
      end else if (e_adj <= E_ZERO) begin
         result.sign        = sign;
         flags[TFR_FLAG_UF] = 1'b1;
      end else begin
         result.sign = sign;
         result.exp  = e_adj[EXP_W-1:0];
         result.man  = man_rnd[MAN_W-1:0];
      end
   end

endmodule

// File: rtl/vx_tcu_tfr_normalize.sv
// Fixed-point dot-product sum to packed float: 3-stage bubble-collapsing valid/ready pipeline,
// 1 beat/cycle; outputs hold while valid_out & ~ready_out.
module vx_tcu_tfr_normalize
   import vx_tcu_tfr_normalize_pkg::*;
(
   input logic                    clk,
   input logic                    reset,
   vx_tcu_tfr_normalize_if.slave  bus
);

   logic                 load1, load2, load3, adv1, adv2;

   logic                 v1, sign1;
   logic [SUM_W-1:0]     mag1;
   logic [EXP_W-1:0]     exp1;
   logic [TAG_W-1:0]     tag1;

   logic                 v2, sign2;
   logic [SUM_W-1:0]     norm2;
   logic signed [EW-1:0] e2;
   logic [TAG_W-1:0]     tag2;

   logic [SUM_W-1:0]     mag_in;
   logic [LZC_W-1:0]     p;
   logic [LZC_W-1:0]     shamt;
   logic [SUM_W-1:0]     norm_s2;
   logic signed [EW-1:0] e_s2;
   tfr_result_t          res_s3;
   logic [2:0]           flg_s3;

   assign load3        = ~bus.valid_out | bus.ready_out;
   assign adv2         = v2 & load3;
   assign load2        = ~v2 | adv2;
   assign adv1         = v1 & load2;
   assign load1        = ~v1 | adv1;
   assign bus.ready_in = load1;

   // Negating the most negative sum yields 2^(SUM_W-1), which is the correct unsigned magnitude.
   assign mag_in  = bus.sum_in[SUM_W-1] ? (~bus.sum_in + SUM_W'(1)) : bus.sum_in;

   assign p       = lead_one(mag1);
   assign shamt   = LZC_W'(SUM_W - 1) - p;
   assign norm_s2 = mag1 << shamt;
   assign e_s2    = $signed(EW'(exp1)) + $signed(EW'(p)) - $signed(EW'(FRAC_W));

   vx_tcu_tfr_normalize_round u_round (
      .sign   (sign2),
      .norm   (norm2),
      .exp    (e2),
      .result (res_s3),
      .flags  (flg_s3)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         v1             <= 1'b0;
         v2             <= 1'b0;
         bus.valid_out  <= 1'b0;
         bus.result_out <= '0;
         bus.flags_out  <= '0;
         bus.tag_out    <= '0;
      end else begin
         if (load1) begin
            v1 <= bus.valid_in;
            if (bus.valid_in) begin
               sign1 <= bus.sum_in[SUM_W-1];
               mag1  <= mag_in;
               exp1  <= bus.max_exp_in;
               tag1  <= bus.tag_in;
            end
         end
         if (load2) begin
            v2 <= v1;
            if (adv1) begin
               sign2 <= sign1;
               norm2 <= norm_s2;
               e2    <= e_s2;
               tag2  <= tag1;
            end
         end
         if (load3) begin
            bus.valid_out <= v2;
            if (adv2) begin
               bus.result_out <= res_s3;
               bus.flags_out  <= flg_s3;
               bus.tag_out    <= tag2;
            end
         end
      end
   end

endmodule

// File: tb/tb_vx_tcu_tfr_normalize.sv
// Randomised bench for the TFR normaliser with an arithmetic reference model and scoreboard.
module tb_vx_tcu_tfr_normalize;
   import vx_tcu_tfr_normalize_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      logic [7:0]  tag;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vx_tcu_tfr_normalize_if bus ();

   vx_tcu_tfr_normalize dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          inflight = 0;
   bit          lat_mode = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_res;
   logic [2:0]  prev_flg;
   logic [7:0]  prev_tag;
   logic [7:0]  tag_ctr = 8'd0;
   exp_t        q[$];

   logic [27:0] d_sum [9] = '{28'h0800000, 28'hF400000, 28'h8000000, 28'h1000001, 28'h1000003,
                              28'h1FFFFFF, 28'h4000000, 28'h0100000, 28'h0000000};
   logic [7:0]  d_exp [9] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd1, 8'd127};
   logic [31:0] d_res [9] = '{32'h3F800000, 32'hBFC00000, 32'hC1800000, 32'h40000000, 32'h40000002,
                              32'h40800000, 32'h7F800000, 32'h00000000, 32'h00000000};
   logic [2:0]  d_flg [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Value = sum * 2^(exp-127-23): keep 24 significant bits, round half to even on the remainder.
   function automatic void model(input logic [27:0] sum, input logic [7:0] ex,
                                 output logic [31:0] res, output logic [2:0] fl);
      longint v, mag, qv, rem, half;
      int     p, e;
      bit     s;
      v   = longint'($signed(sum));
      s   = (v < 0);
      mag = s ? -v : v;
      if (mag == 0) begin
         res = 32'h0;
         fl  = 3'b100;
         return;
      end
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      if (p > 23) begin
         qv   = mag >> (p - 23);
         rem  = mag - (qv << (p - 23));
         half = longint'(1) << (p - 24);
         if (rem > half || (rem == half && qv[0])) qv++;
      end else begin
         qv = mag << (23 - p);
      end
      e = int'(ex) + p - 23;
      if (qv == (longint'(1) << 24)) begin
         qv = qv >> 1;
         e++;
      end
      if (e >= 255) begin
         res = {s, 8'hFF, 23'h0};
         fl  = 3'b010;
      end else if (e <= 0) begin
         res = {s, 31'h0};
         fl  = 3'b001;
      end else begin
         res = {s, e[7:0], qv[22:0]};
         fl  = 3'b000;
      end
   endfunction

   function automatic logic [27:0] rand_sum();
      logic [31:0] v;
      int          sh;
      sh = int'($urandom_range(0, 27));
      v  = $urandom & ((32'd1 << (sh + 1)) - 32'd1);
      case ($urandom_range(0, 15))
         0: v = 32'h0;
         1: v = 32'h8000000;
         2: v = 32'h1FFFFFF;
         default: ;
      endcase
      if ($urandom_range(0, 1) == 1) v = -v;
      return v[27:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [27:0] s, input logic [7:0] e);
      bus.valid_in   = 1'b1;
      bus.sum_in     = s;
      bus.max_exp_in = e;
      bus.tag_in     = tag_ctr;
      tag_ctr++;
   endtask

   // Scoreboard / protocol monitor, sampling mid-cycle.
   always @(negedge clk) begin
      exp_t        ex;
      logic [31:0] r;
      logic [2:0]  f;
      bit          rdy_req;
      cyc++;
      if (reset) begin
         q.delete();
         inflight   = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_vld", 32'(bus.valid_out), 32'd1);
            chk("stall_res", bus.result_out, prev_res);
            chk("stall_flg", 32'(bus.flags_out), 32'(prev_flg));
            chk("stall_tag", 32'(bus.tag_out), 32'(prev_tag));
         end
         rdy_req = !(inflight == 3 && bus.valid_out && !bus.ready_out);
         chk("ready_in", 32'(bus.ready_in), 32'(rdy_req));
         if (bus.valid_out) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious: valid_out=1 with tag %h, want no beat (cycle %0d)", bus.tag_out, cyc);
            end else if (bus.ready_out) begin
               ex = q.pop_front();
               inflight--;
               chk("result", bus.result_out, ex.res);
               chk("flags", 32'(bus.flags_out), 32'(ex.flg));
               chk("tag", 32'(bus.tag_out), 32'(ex.tag));
               if (lat_mode) chk("latency", 32'(cyc - ex.acc), 32'd3);
            end
         end
         prev_stall = bus.valid_out && !bus.ready_out;
         prev_res   = bus.result_out;
         prev_flg   = bus.flags_out;
         prev_tag   = bus.tag_out;
         if (bus.valid_in && bus.ready_in) begin
            model(bus.sum_in, bus.max_exp_in, r, f);
            q.push_back('{res: r, flg: f, tag: bus.tag_in, acc: cyc});
            inflight++;
         end
      end
   end

   initial begin
      logic [31:0] r;
      logic [2:0]  f;
      bit          got;

      reset          = 1'b1;
      bus.valid_in   = 1'b0;
      bus.sum_in     = '0;
      bus.max_exp_in = '0;
      bus.tag_in     = '0;
      bus.ready_out  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", 32'(bus.valid_out), 32'd0);
      chk("rst_res", bus.result_out, 32'd0);
      chk("rst_flg", 32'(bus.flags_out), 32'd0);
      chk("rst_tag", 32'(bus.tag_out), 32'd0);
      step();
      reset = 1'b0;
      step();

      // Hand-computed vectors: pin the model, then send each beat through an idle pipe.
      bus.ready_out = 1'b1;
      lat_mode      = 1'b1;
      for (int i = 0; i < 9; i++) begin
         model(d_sum[i], d_exp[i], r, f);
         chk("pin_res", r, d_res[i]);
         chk("pin_flg", 32'(f), 32'(d_flg[i]));
         drive_beat(d_sum[i], d_exp[i]);
         step();
         bus.valid_in = 1'b0;
         repeat (4) step();
      end

      // Random traffic at full downstream throughput.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 7) drive_beat(rand_sum(), 8'($urandom_range(0, 255)));
         else bus.valid_in = 1'b0;
         step();
      end
      bus.valid_in = 1'b0;
      repeat (6) step();

      // Backpressure: 8 held beats, then random valid/ready traffic.
      lat_mode = 1'b0;
      for (int b = 0; b < 8; b++) begin
         drive_beat(rand_sum(), 8'($urandom_range(0, 255)));
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = bus.ready_in;
            @(posedge clk);
            #1;
            bus.ready_out = 1'($urandom_range(0, 1));
         end
         if (!got) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ready_in stayed 0, want 1 within 100 cycles");
         end
      end
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) drive_beat(rand_sum(), 8'($urandom_range(0, 255)));
         else bus.valid_in = 1'b0;
         bus.ready_out = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b1;
      for (int k = 0; k < 50 && q.size() != 0; k++) step();
      chk("drain_bp", 32'(q.size()), 32'd0);
      repeat (2) step();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         drive_beat(rand_sum(), 8'($urandom_range(100, 150)));
         step();
      end
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b0;
      reset         = 1'b1;
      step();
      reset         = 1'b0;
      bus.ready_out = 1'b1;
      @(negedge clk);
      chk("rst_flush", 32'(bus.valid_out), 32'd0);
      @(posedge clk);
      #1;
      repeat (2) step();
      lat_mode = 1'b1;
      drive_beat(28'h0800000, 8'd130);
      step();
      bus.valid_in = 1'b0;
      for (int k = 0; k < 10 && q.size() != 0; k++) step();
      chk("drain_rst", 32'(q.size()), 32'd0);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vx_tcu_tfr_normalize.md
Name: VX_tcu_tfr_normalize

Overview:
Output-side counterpart to the TFR max-exponent/alignment front end. It takes the signed fixed-point dot-product sum, which is aligned to the shared maximum exponent, and produces a packed IEEE-style float. The conversion covers sign extraction, leading-one detection, left/right normalisation, round-to-nearest-even, and exponent adjustment with overflow/underflow handling. The block is a 3-stage valid/ready pipeline between the TFR adder tree and the accumulator writeback.

Parameters:
EXP_W, 8, exponent width of the shared max exponent and of the result
MAN_W, 23, stored mantissa width of the result, excluding the hidden bit
FRAC_W, 23, fractional bits of sum_in relative to max_exp_in
SUM_W, 28, width of the two's-complement sum_in
TAG_W, 8, sideband tag width, passed through unchanged

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  block can accept a beat
sum_in  in  SUM_W  signed sum; value = sum_in × 2^(max_exp_in − BIAS − FRAC_W), where BIAS = 2^(EXP_W−1)−1
max_exp_in  in  EXP_W  shared biased exponent from the max-exp stage
tag_in  in  TAG_W  sideband
valid_out  out  1  result valid
ready_out  in  1  downstream accepts
result_out  out  1+EXP_W+MAN_W  packed {sign, exp, man}
flags_out  out  3  {zero, overflow, underflow}
tag_out  out  TAG_W  tag aligned with result_out

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on the port reset. Reset clears all stage valids and valid_out. result_out, flags_out and tag_out reset to 0. A reset mid-operation discards all in-flight beats; there is no partial output after reset.
- Pipeline:
  - S1: sign = sum_in[SUM_W−1]; mag = |sum_in| as SUM_W-bit unsigned (−2^(SUM_W−1) gives mag = 2^(SUM_W−1), no wrap).
  - S2: p = index of the leading one of mag. Left-shift mag so the leading one sits at bit SUM_W−1. Compute e = max_exp_in + p − FRAC_W as signed (EXP_W+2)-bit.
  - S3: keep MAN_W bits below the leading one. Guard = next bit; sticky = OR of the remaining bits. Apply RNE: round up if guard & (sticky | lsb). A mantissa carry-out zeros the mantissa and increments e. Then pack and register the outputs.
- Handshake:
  - Each stage register loads when it is empty or its successor is advancing (bubble-collapsing).
  - ready_in = ~v1 | adv1. Output advances on valid_out & ready_out.
  - Latency is 3 cycles from acceptance to valid_out with ready_out held high. Throughput is 1 beat/cycle.
  - While valid_out & ~ready_out, result_out/flags_out/tag_out are held stable.
  - valid_in is not required to be held; a beat is consumed only when valid_in & ready_in.
- Boundary cases:
  - mag == 0: result = +0 (all zero), zero flag = 1, sign forced to 0.
  - e ≥ 2^EXP_W − 1 after rounding: result = {sign, all-ones, 0} (infinity), overflow = 1.
  - e ≤ 0 after rounding: result = {sign, 0, 0}, underflow = 1. No subnormals are produced (flush-to-zero).
  - p ≤ MAN_W: exact left shift, so guard = sticky = 0.
  - At most one flag is set per beat.
- Width rules: internal exponent arithmetic is signed EXP_W+2 bits throughout, with no intermediate truncation. LZC width is $clog2(SUM_W).

Decomposition:
- Shared package VX_tcu_pkg gets:
  - flag bit index constants TFR_FLAG_ZERO=2, TFR_FLAG_OVF=1, TFR_FLAG_UF=0;
  - a packed struct type for the {sign, exp, man} result.
- One sub-module, VX_tcu_tfr_round. It is combinational: it takes the shifted magnitude and e, and returns the rounded mantissa, the adjusted exponent and the flags. It is instantiated in S3.
- Leading-zero count uses the existing shared LZC primitive.

Test Plan:
- Single value: sum_in=1<<23, max_exp_in=127 → result 0x3F800000, flags 0, valid_out exactly 3 cycles after acceptance.
- Negative and minimum value: sum_in=−(3<<22), exp 127 → 0xBFC00000. sum_in=−2^27, exp 127 → 0xC1800000 (−16.0).
- RNE tie: sum_in=(1<<24)|1, exp 127 → 0x40000000. Sum (1<<24)|3 → 0x40000002. Sum 0x1FFFFFF (p=24, all ones) → rounds up with carry → 0x40800000.
- Overflow, underflow and zero:
  - max_exp_in=254, sum_in=1<<26 → 0x7F800000, flags=3'b010.
  - max_exp_in=1, sum_in=1<<20 → 0x00000000, flags=3'b001.
  - sum_in=0 → 0x00000000, flags=3'b100.
- Backpressure: stream 8 beats with distinct tags while ready_out toggles in a random pattern. Required: results in order, none dropped or duplicated, outputs stable while stalled, ready_in low only when all 3 stages are full and the output is stalled.
- Reset mid-stream: assert reset for 1 cycle with 3 beats in flight. Required: valid_out=0 the following cycle, no stale beat emerges, and the next accepted beat appears after 3 cycles.
